elevator_car_model: RTL and testbench

Cycle-accurate model of the elevator car and shaft for a three-floor building. It consumes the controller's 2-bit motor command and door signal and produces the floor-sensor pulses the controller waits on, plus position and fault status. It closes the loop in system-level benches and serves as the plant on FPGA demo builds.

---
 rtl/elevator_car_model.sv | 128 ++++++++++++
 tb/tb_elevator_car_model.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/elevator_car_model.sv
// Plant model of a three-floor elevator car: turns motor/door commands into
// shaft position, floor-arrival sensor pulses and a sticky fault flag.
module elevator_car_model #(
  parameter int TRAVEL_CYCLES = 8,
  parameter int START_CYCLES  = 2
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [1:0]                               ac,
  input  logic                                     doorOpen,
  output logic                                     s1,
  output logic                                     s2,
  output logic                                     s3,
  output logic [1:0]                               floor,
  output logic                                     moving,
  output logic                                     fault,
  output logic [$clog2(2*TRAVEL_CYCLES+1)-1:0]     pos
);

  localparam int PW = $clog2(2*TRAVEL_CYCLES+1);
  localparam int CW = $clog2(START_CYCLES+1);
  localparam logic [PW-1:0] TOP_POS = PW'(2*TRAVEL_CYCLES);
  localparam logic [PW-1:0] MID_POS = PW'(TRAVEL_CYCLES);

  typedef enum logic [1:0] {IDLE, START, MOVE, FAULT} state_t;

  state_t          state_q, state_d;
  logic            dir_q, dir_d;       // 1 = up
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   pos_q, pos_d;
  logic [1:0]      floor_q, floor_d;
  logic [2:0]      sens_q, sens_d;

  logic [PW-1:0]   step_pos;
  logic            reversed, illegal;

  assign step_pos = dir_q ? pos_q + PW'(1) : pos_q - PW'(1);
  assign reversed = dir_q ? (ac == 2'b10) : (ac == 2'b01);
  // Any of these while committed to a motion is unrecoverable.
  assign illegal  = doorOpen || (ac == 2'b11) || reversed;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    floor_d = floor_q;
    sens_d  = 3'b000;
    unique case (state_q)
      IDLE: begin
        unique case (ac)
          2'b01: begin
            if (pos_q == TOP_POS) state_d = FAULT;
            else begin
              dir_d   = 1'b1;
              cnt_d   = CW'(1);
              state_d = (START_CYCLES == 1) ? MOVE : START;
            end
          end
          2'b10: begin
            if (pos_q == '0) state_d = FAULT;
            else begin
              dir_d   = 1'b0;
              cnt_d   = CW'(1);
              state_d = (START_CYCLES == 1) ? MOVE : START;
            end
          end
          2'b11:   state_d = FAULT;
          default: state_d = IDLE;
        endcase
      end
      START: begin
        if (illegal)                          state_d = FAULT;
        else if (ac == 2'b00)                 state_d = IDLE;
        else if (cnt_q == CW'(START_CYCLES-1)) state_d = MOVE;
        else                                  cnt_d   = cnt_q + CW'(1);
      end
      MOVE: begin
        if (illegal)          state_d = FAULT;
        else if (ac == 2'b00) state_d = IDLE;
        else begin
          pos_d = step_pos;
          // End positions stop the car on the landing edge itself.
          if (step_pos == '0) begin
            floor_d = 2'd1;
            sens_d  = 3'b001;
            state_d = IDLE;
          end else if (step_pos == MID_POS) begin
            floor_d = 2'd2;
            sens_d  = 3'b010;
          end else if (step_pos == TOP_POS) begin
            floor_d = 2'd3;
            sens_d  = 3'b100;
            state_d = IDLE;
          end
        end
      end
      default: state_d = FAULT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dir_q   <= 1'b1;
      cnt_q   <= '0;
      pos_q   <= '0;
      floor_q <= 2'd1;
      sens_q  <= 3'b000;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      floor_q <= floor_d;
      sens_q  <= sens_d;
    end
  end

  assign s1     = sens_q[0];
  assign s2     = sens_q[1];
  assign s3     = sens_q[2];
  assign floor  = floor_q;
  assign pos    = pos_q;
  assign moving = (state_q == MOVE);
  assign fault  = (state_q == FAULT);

endmodule

// File: tb/tb_elevator_car_model.sv
// Directed scenarios plus randomized command streams, every cycle compared
// against an abstract car model (run flag, spin-up countdown, integer position).
module tb_elevator_car_model;

  localparam int T   = 8;
  localparam int SC  = 2;
  localparam int TOP = 2*T;

  logic       clk, rst_n;
  logic [1:0] ac;
  logic       doorOpen;
  logic       s1, s2, s3, moving, fault;
  logic [1:0] floor;
  logic [4:0] pos;

  int checks, failures;

  // reference model state
  bit m_fault, m_run;
  int m_dir, m_wait, m_pos, m_floor, m_sens;

  elevator_car_model #(.TRAVEL_CYCLES(T), .START_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .ac(ac), .doorOpen(doorOpen),
    .s1(s1), .s2(s2), .s3(s3), .floor(floor), .moving(moving),
    .fault(fault), .pos(pos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fault = 0; m_run = 0; m_dir = 1; m_wait = 0;
    m_pos = 0; m_floor = 1; m_sens = 0;
  endtask

  task automatic model_step(input int a, input bit d);
    int opp;
    m_sens = 0;
    if (m_fault) begin
    end else if (!m_run) begin
      if (a == 3 || (a == 1 && m_pos == TOP) || (a == 2 && m_pos == 0)) m_fault = 1;
      else if (a != 0) begin
        m_run = 1; m_dir = (a == 1) ? 1 : -1; m_wait = SC - 1;
      end
    end else begin
      opp = (m_dir == 1) ? 2 : 1;
      if (d || a == 3 || a == opp) m_fault = 1;
      else if (a == 0) begin m_run = 0; m_wait = 0; end
      else if (m_wait > 0) m_wait--;
      else begin
        m_pos += m_dir;
        if (m_pos % T == 0) begin
          m_floor = m_pos / T + 1;
          m_sens  = m_floor;
          if (m_pos == 0 || m_pos == TOP) m_run = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("pos",    pos,    m_pos);
    chk("floor",  floor,  m_floor);
    chk("moving", moving, (m_run && m_wait == 0 && !m_fault) ? 1 : 0);
    chk("fault",  fault,  m_fault);
    chk("s1", s1, (m_sens == 1) ? 1 : 0);
    chk("s2", s2, (m_sens == 2) ? 1 : 0);
    chk("s3", s3, (m_sens == 3) ? 1 : 0);
  endtask

  // called at a falling edge; returns at the next falling edge
  task automatic cyc(input logic [1:0] a, input logic d = 1'b0);
    ac = a; doorOpen = d;
    @(posedge clk);
    model_step(int'(a), d);
    #1 compare_all();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ac = 2'b00; doorOpen = 1'b0;
    #1 model_reset();
    compare_all();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] a;
    bit d;
    int r;
    checks = 0; failures = 0;
    rst_n = 1'b0; ac = 2'b00; doorOpen = 1'b0;
    @(negedge clk);

    // up one floor
    do_reset();
    cyc(2'b01); chk("up1_moving_e0", moving, 0);
    cyc(2'b01); chk("up1_moving_e1", moving, 1);
    for (int i = 2; i <= 9; i++) cyc(2'b01);
    chk("up1_pos", pos, 8); chk("up1_s2", s2, 1); chk("up1_floor", floor, 2);
    cyc(2'b00); chk("up1_s2_off", s2, 0); chk("up1_idle", moving, 0);

    // up two floors, then back down
    do_reset();
    for (int i = 0; i <= 17; i++) begin
      cyc(2'b01);
      if (i == 9)  chk("up2_s2", s2, 1);
      if (i == 17) begin chk("up2_s3", s3, 1); chk("up2_pos", pos, 16); end
    end
    cyc(2'b00); chk("up2_stopped", moving, 0); chk("up2_nofault", fault, 0);
    for (int i = 0; i <= 17; i++) begin
      cyc(2'b10);
      if (i == 9)  chk("dn_s2", s2, 1);
      if (i == 17) begin chk("dn_s1", s1, 1); chk("dn_pos", pos, 0); chk("dn_floor", floor, 1); end
    end
    cyc(2'b00);

    // stop mid-shaft
    do_reset();
    for (int i = 0; i < 5; i++) cyc(2'b01);
    for (int i = 0; i < 3; i++) cyc(2'b00);
    chk("mid_pos", pos, 3); chk("mid_floor", floor, 1); chk("mid_moving", moving, 0);

    // reversal while moving
    do_reset();
    for (int i = 0; i < 5; i++) cyc(2'b01);
    cyc(2'b10); chk("rev_fault", fault, 1); chk("rev_pos", pos, 3);
    for (int i = 0; i < 4; i++) cyc(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    chk("rev_frozen", pos, 3);
    do_reset();
    chk("rev_cleared", fault, 0);

    // illegal command from idle
    cyc(2'b11); chk("ill_fault", fault, 1);
    // door open while moving
    do_reset();
    for (int i = 0; i < 4; i++) cyc(2'b01);
    cyc(2'b01, 1'b1); chk("door_fault", fault, 1); chk("door_pos", pos, 2);
    // down at bottom
    do_reset();
    cyc(2'b10); chk("bot_fault", fault, 1); chk("bot_pos", pos, 0);

    // asynchronous reset mid-cycle at pos 5
    do_reset();
    for (int i = 0; i < 7; i++) cyc(2'b01);
    chk("ar_pos5", pos, 5);
    #2 do_reset();

    // randomized command streams
    for (int run = 0; run < 30; run++) begin
      do_reset();
      a = 2'b00;
      for (int c = 0; c < 60; c++) begin
        r = $urandom_range(0, 99);
        if (r < 60)      a = a;
        else if (r < 75) a = 2'b00;
        else if (r < 87) a = 2'b01;
        else if (r < 97) a = 2'b10;
        else             a = 2'b11;
        d = ($urandom_range(0, 99) < 3);
        cyc(a, d);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
